// File: rtl/systolic_pkg.sv
// Shared fixed-point format constants and control FSM encoding for the systolic engine.
package systolic_pkg;

    localparam int A_FRAC_BITS    = 10;  // S5.10 operand / result
    localparam int B_FRAC_BITS    = 6;   // S1.6 weight
    localparam int PROD_FRAC_BITS = A_FRAC_BITS + B_FRAC_BITS;

    // Rescales the S?.16 accumulator back to the S5.10 result grid.
    localparam int DEFAULT_FRAC_SHIFT = PROD_FRAC_BITS - A_FRAC_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StCompute,
        StConvert,
        StDone
    } state_e;

endpackage

// File: rtl/systolic_pe_mac.sv
// Output-stationary PE: registers data/weight through to its neighbours and accumulates
// their signed product; clear zeroes both the accumulator and the pass-through registers.
module systolic_pe_mac #(
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic [DATA_WIDTH-1:0]   a_in,
    input  logic [WEIGHT_WIDTH-1:0] b_in,
    output logic [DATA_WIDTH-1:0]   a_out,
    output logic [WEIGHT_WIDTH-1:0] b_out,
    output logic [ACCUM_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;

    logic [PROD_WIDTH-1:0]  a_ext;
    logic [PROD_WIDTH-1:0]  b_ext;
    logic [PROD_WIDTH-1:0]  prod;
    logic [ACCUM_WIDTH-1:0] prod_ext;

    // Low PROD_WIDTH bits of the product of sign-extended operands is the exact signed product.
    assign a_ext    = {{WEIGHT_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
    assign b_ext    = {{DATA_WIDTH{b_in[WEIGHT_WIDTH-1]}}, b_in};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(ACCUM_WIDTH - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (clear) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (en) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic matrix multiplier (S5.10 x S1.6 -> S5.10).
// Build option: define SYSTOLIC_SAT_EN to saturate results and flag overflow in ovf_flat.
module systolic_mm_engine
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE   = 4,
    parameter int DATA_WIDTH   = 16,
    parameter int WEIGHT_WIDTH = 8,
    parameter int ACCUM_WIDTH  = 32,
    parameter int FRAC_SHIFT   = DEFAULT_FRAC_SHIFT
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]   matrix_a_flat,
    input  logic [WEIGHT_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0] matrix_b_flat,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      result_valid,
    output logic [DATA_WIDTH*ARRAY_SIZE*ARRAY_SIZE-1:0]   result_flat,
    output logic [ARRAY_SIZE*ARRAY_SIZE-1:0]          ovf_flat
);

    localparam int N     = ARRAY_SIZE;
    localparam int NN    = N * N;
    localparam int CYC_W = $clog2(3 * N);
    localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(3 * N - 3);

    state_e state_q, state_d;
    logic [CYC_W-1:0] cyc_q;
    logic             accept;
    logic             compute;

    logic [NN-1:0][DATA_WIDTH-1:0]   a_q;
    logic [NN-1:0][WEIGHT_WIDTH-1:0] b_q;
    logic [N-1:0][DATA_WIDTH-1:0]    a_feed;
    logic [N-1:0][WEIGHT_WIDTH-1:0]  b_feed;

    logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   a_out_bus;
    logic [N-1:0][N-1:0][WEIGHT_WIDTH-1:0] b_out_bus;
    logic [NN-1:0][ACCUM_WIDTH-1:0]        acc_bus;

    logic [NN-1:0][DATA_WIDTH-1:0] conv_d;
    logic [NN-1:0][DATA_WIDTH-1:0] result_q;
    logic                          valid_q;

    assign accept  = (state_q == StIdle) && start;
    assign compute = (state_q == StCompute);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCompute;
            StCompute: if (cyc_q == LAST_CYC) state_d = StConvert;
            StConvert: state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cyc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cyc_q <= '0;
                a_q   <= matrix_a_flat;
                b_q   <= matrix_b_flat;
            end else if (compute) begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    // Row i of A and column j of B enter i (resp. j) cycles late so operand k meets at PE(i,j).
    always_comb begin
        a_feed = '0;
        b_feed = '0;
        if (compute) begin
            for (int i = 0; i < N; i++) begin
                if (int'(cyc_q) >= i && int'(cyc_q) - i < N) begin
                    a_feed[i] = a_q[IDX_W'(i * N + int'(cyc_q) - i)];
                    b_feed[i] = b_q[IDX_W'((int'(cyc_q) - i) * N + i)];
                end
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic [DATA_WIDTH-1:0]   a_in_w;
            logic [WEIGHT_WIDTH-1:0] b_in_w;

            if (j == 0) begin : g_a_edge
                assign a_in_w = a_feed[i];
            end else begin : g_a_hop
                assign a_in_w = a_out_bus[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign b_in_w = b_feed[j];
            end else begin : g_b_hop
                assign b_in_w = b_out_bus[i-1][j];
            end

            systolic_pe_mac #(
                .DATA_WIDTH  (DATA_WIDTH),
                .WEIGHT_WIDTH(WEIGHT_WIDTH),
                .ACCUM_WIDTH (ACCUM_WIDTH)
            ) u_pe (
                .clk  (clk),
                .rst  (rst),
                .clear(accept),
                .en   (compute),
                .a_in (a_in_w),
                .b_in (b_in_w),
                .a_out(a_out_bus[i][j]),
                .b_out(b_out_bus[i][j]),
                .acc  (acc_bus[i*N+j])
            );
        end
    end

`ifdef SYSTOLIC_SAT_EN
    localparam int HI_W = ACCUM_WIDTH - FRAC_SHIFT - DATA_WIDTH + 1;

    logic [NN-1:0] ovf_d;
    logic [NN-1:0] ovf_q;
    logic [HI_W-1:0] hi;

    // In range iff every accumulator bit from the result sign bit upward agrees.
    always_comb begin
        conv_d = '0;
        ovf_d  = '0;
        hi     = '0;
        for (int e = 0; e < NN; e++) begin
            hi = acc_bus[e][ACCUM_WIDTH-1 -: HI_W];
            if (hi == '0 || hi == '1) begin
                conv_d[e] = acc_bus[e][FRAC_SHIFT +: DATA_WIDTH];
            end else begin
                conv_d[e] = hi[HI_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
                ovf_d[e]  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (accept) begin
            ovf_q <= '0;
        end else if (state_q == StConvert) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_flat = ovf_q;
`else
    always_comb begin
        conv_d = '0;
        for (int e = 0; e < NN; e++) begin
            conv_d[e] = acc_bus[e][FRAC_SHIFT +: DATA_WIDTH];
        end
    end

    assign ovf_flat = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b0;
        end else if (state_q == StConvert) begin
            result_q <= conv_d;
            valid_q  <= 1'b1;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign result_valid = valid_q;
    assign result_flat  = result_q;

    // Edge PE outputs and unscaled accumulator bits have no consumer.
    logic unused_bits;
    assign unused_bits = ^{a_out_bus, b_out_bus, acc_bus};

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed-vector and reference-model bench for systolic_mm_engine at N=2 and N=4.
// Expectations follow SYSTOLIC_SAT_EN when the bench is built with it.
module tb_systolic_mm_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         start2 = 1'b0;
    logic [63:0]  a2 = '0;
    logic [31:0]  b2 = '0;
    logic         busy2, done2, valid2;
    logic [63:0]  res2;
    logic [3:0]   ovf2;

    logic         start4 = 1'b0;
    logic [255:0] a4 = '0;
    logic [127:0] b4 = '0;
    logic         busy4, done4, valid4;
    logic [255:0] res4;
    logic [15:0]  ovf4;

    systolic_mm_engine #(.ARRAY_SIZE(2)) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .matrix_a_flat(a2),
        .matrix_b_flat(b2),
        .busy         (busy2),
        .done         (done2),
        .result_valid (valid2),
        .result_flat  (res2),
        .ovf_flat     (ovf2)
    );

    systolic_mm_engine #(.ARRAY_SIZE(4)) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .start        (start4),
        .matrix_a_flat(a4),
        .matrix_b_flat(b4),
        .busy         (busy4),
        .done         (done4),
        .result_valid (valid4),
        .result_flat  (res4),
        .ovf_flat     (ovf4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Bit-accurate N=4 reference: 32-bit wrapping sum, arithmetic shift by 6, then narrow.
    function automatic void model4(input logic [255:0] a, input logic [127:0] b,
                                   output logic [255:0] c, output logic [15:0] o);
        c = '0;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                int acc;
                int sh;
                logic [31:0] shv;
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc + int'($signed(a[(i*4+k)*16 +: 16])) * int'($signed(b[(k*4+j)*8 +: 8]));
                end
                sh  = acc >>> 6;
                shv = sh;
`ifdef SYSTOLIC_SAT_EN
                if (sh > 32767) begin
                    shv = 32'h7FFF;
                    o[i*4+j] = 1'b1;
                end else if (sh < -32768) begin
                    shv = 32'h8000;
                    o[i*4+j] = 1'b1;
                end
`endif
                c[(i*4+j)*16 +: 16] = shv[15:0];
            end
        end
    endfunction

    // Counts negedges until done4 is seen; n = 0 means the budget ran out.
    task automatic wait_done4(input int budget, output int n);
        n = 0;
        for (int k = 1; k <= budget && n == 0; k++) begin
            @(negedge clk);
            if (done4) n = k;
        end
    endtask

    // lat = index of the clock edge (counting the accepting edge as 0) that ends the done cycle.
    task automatic job2(input logic [63:0] a, input logic [31:0] b, output logic [63:0] res,
                        output logic [3:0] ovf, output logic vld, output int lat);
        @(negedge clk);
        a2 = a; b2 = b; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 0; res = '0; ovf = '0; vld = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (done2) begin
                lat = k + 1; res = res2; ovf = ovf2; vld = valid2;
            end
        end
    endtask

    task automatic job4(input logic [255:0] a, input logic [127:0] b, output int lat);
        int n;
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait_done4(60, n);
        lat = (n == 0) ? 0 : n + 1;
    endtask

    typedef struct {
        logic [63:0] a;
        logic [31:0] b;
        logic [63:0] c;
    } vec2_t;

    vec2_t tbl[4];

    initial begin
        logic [63:0]  r2;
        logic [3:0]   o2;
        logic         v2;
        int           lat;
        int           n;
        int           dcount;
        logic [255:0] x_a, exp4;
        logic [127:0] x_b;
        logic [15:0]  expo4;

        // identity
        tbl[0] = '{a: {16'h0400, 16'h0000, 16'h0000, 16'h0400}, b: {8'h40, 8'h00, 8'h00, 8'h40},
                   c: {16'h0400, 16'h0000, 16'h0000, 16'h0400}};
        // -1.0 * 0.5 in the corner only
        tbl[1] = '{a: {16'h0000, 16'h0000, 16'h0000, 16'hFC00}, b: {8'h00, 8'h00, 8'h00, 8'h20},
                   c: {16'h0000, 16'h0000, 16'h0000, 16'hFE00}};
        // all ones: each element sums two 1.0 products
        tbl[2] = '{a: {4{16'h0400}}, b: {4{8'h40}}, c: {4{16'h0800}}};
        // A=[[1,2],[-1,0.5]] B=[[0.5,1],[-1,0]] -> [[-1.5,1],[-1,-1]]
        tbl[3] = '{a: {16'h0200, 16'hFC00, 16'h0800, 16'h0400}, b: {8'h00, 8'hC0, 8'h40, 8'h20},
                   c: {16'hFC00, 16'hFC00, 16'h0400, 16'hFA00}};

        repeat (2) @(negedge clk);
        check("reset busy", {busy4, busy2}, 2'b00);
        check("reset done", {done4, done2}, 2'b00);
        check("reset result_valid", {valid4, valid2}, 2'b00);
        check("reset result n4", res4, '0);
        check("reset result n2", res2, '0);
        check("reset ovf", {ovf4, ovf2}, '0);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            job2(tbl[v].a, tbl[v].b, r2, o2, v2, lat);
            check($sformatf("n2 vec%0d result", v), r2, tbl[v].c);
            check($sformatf("n2 vec%0d ovf", v), o2, 4'b0000);
            check($sformatf("n2 vec%0d valid", v), v2, 1'b1);
            check($sformatf("n2 vec%0d done edge", v), lat, 6);
        end
        repeat (3) @(negedge clk);
        check("n2 result held", res2, tbl[3].c);
        check("n2 valid held", valid2, 1'b1);

        // Row 0 of A all 31.0, column 0 of B all ~1.98: C[0][0] overflows 16 bits.
        x_a = '0;
        x_b = '0;
        for (int k = 0; k < 4; k++) begin
            x_a[k*16 +: 16]    = 16'h7C00;
            x_b[(k*4)*8 +: 8]  = 8'h7F;
        end
        job4(x_a, x_b, lat);
`ifdef SYSTOLIC_SAT_EN
        check("n4 overflow result", res4, 256'h7FFF);
        check("n4 overflow flag", ovf4, 16'h0001);
`else
        check("n4 overflow result", res4, 256'hD840);
        check("n4 overflow flag", ovf4, 16'h0000);
`endif
        check("n4 done edge", lat, 12);

        // Second start three cycles into COMPUTE must be ignored.
        x_a = '0;
        for (int d = 0; d < 4; d++) x_a[(d*5)*16 +: 16] = 16'h0400;
        for (int e = 0; e < 16; e++) x_b[e*8 +: 8] = 8'(e * 7 + 3);
        model4(x_a, x_b, exp4, expo4);
        @(negedge clk);
        a4 = x_a; b4 = x_b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        a4 = {16{16'h7FFF}}; b4 = {16{8'h81}}; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        check("ignore busy", busy4, 1'b1);
        wait_done4(60, n);
        check("ignore done edge", (n == 0) ? 0 : n + 5, 12);
        check("ignore result", res4, exp4);

        // Reset in the middle of COMPUTE.
        @(negedge clk);
        a4 = {16{16'h0C00}}; b4 = {16{8'h10}}; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", busy4, 1'b0);
        check("abort done", done4, 1'b0);
        check("abort valid", valid4, 1'b0);
        check("abort result", res4, '0);
        check("abort ovf", ovf4, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (done4) dcount++;
        end
        check("abort no done", dcount, 0);
        for (int e = 0; e < 16; e++) begin
            x_a[e*16 +: 16] = 16'(e * 16'h0123 - 16'h0800);
            x_b[e*8 +: 8]   = 8'(8'h30 - e * 5);
        end
        model4(x_a, x_b, exp4, expo4);
        job4(x_a, x_b, lat);
        check("after abort result", res4, exp4);
        check("after abort ovf", ovf4, expo4);
        check("after abort done edge", lat, 12);

        // 100 random jobs back to back with start held high.
        @(negedge clk);
        for (int e = 0; e < 16; e++) begin
            a4[e*16 +: 16] = 16'($urandom);
            b4[e*8 +: 8]   = 8'($urandom);
        end
        model4(a4, b4, exp4, expo4);
        start4 = 1'b1;
        for (int job = 0; job < 100; job++) begin
            wait_done4(60, n);
            if (n == 0) begin
                check($sformatf("random job %0d done timeout", job), 0, 1);
                break;
            end
            if (job > 0) check($sformatf("random job %0d done interval", job), n, 13);
            check($sformatf("random job %0d result", job), res4, exp4);
            check($sformatf("random job %0d ovf", job), ovf4, expo4);
            for (int e = 0; e < 16; e++) begin
                a4[e*16 +: 16] = 16'($urandom);
                b4[e*8 +: 8]   = 8'($urandom);
            end
            model4(a4, b4, exp4, expo4);
        end
        start4 = 1'b0;
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 SHALL have parameter ARRAY_SIZE, default 4: N, the dimension of the square NxN PE grid and of the operand matrices.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: width of each A element and each result element, signed S5.10.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 8: width of each B element, signed S1.6.
REQ-004 SHALL have parameter ACCUM_WIDTH, default 32: width of each PE accumulator, signed.
REQ-005 SHALL have parameter FRAC_SHIFT, default 6: arithmetic right shift applied to the accumulator on output.
REQ-006 SHALL have port clk, input, 1 bit: the only clock, rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-009 SHALL have port matrix_a_flat, input, DATA_WIDTH*N*N bits: element A[i][j] at slice index i*N+j.
REQ-010 SHALL have port matrix_b_flat, input, WEIGHT_WIDTH*N*N bits: element B[i][j] at slice index i*N+j.
REQ-011 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-012 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-013 SHALL have port result_valid, output, 1 bit: result_flat holds a valid product.
REQ-014 SHALL have port result_flat, output, DATA_WIDTH*N*N bits: element C[i][j] at slice index i*N+j.
REQ-015 SHALL have port ovf_flat, output, N*N bits: per-element saturation flag.

Function
REQ-016 SHALL implement the FSM IDLE -> COMPUTE -> CONVERT -> DONE -> IDLE.
REQ-017 SHALL accept start only in IDLE; on acceptance it captures both operand buses, clears all accumulators, clears result_valid and enters COMPUTE.
REQ-018 SHALL ignore start in COMPUTE, CONVERT and DONE, with no effect on state, operands or outputs.
REQ-019 SHALL, in COMPUTE, feed row i of A skewed by i cycles and column j of B skewed by j cycles, with zeros injected outside the valid window.
REQ-020 SHALL keep COMPUTE for exactly 3N-2 cycles, tracked by a cycle counter.
REQ-021 SHALL make each PE compute acc += sext(a)*sext(b), a full signed DATA_WIDTH+WEIGHT_WIDTH product sign-extended to ACCUM_WIDTH, wrapping modulo 2^ACCUM_WIDTH.
REQ-022 SHALL, in CONVERT, form C[i][j] = acc[i][j] >>> FRAC_SHIFT, narrow it to DATA_WIDTH per REQ-031/032, and register it into result_flat.
REQ-023 SHALL, in DONE, drive done=1 and result_valid=1 for that one cycle, then return to IDLE.
REQ-024 SHALL assert done exactly 3N clock edges after the edge that accepts start (N=2: 6 edges).
REQ-025 SHALL hold result_valid and result_flat stable from DONE until the next accepted start.
REQ-026 SHALL, when start is held high continuously, re-accept it on each IDLE cycle, giving back-to-back jobs every 3N+1 cycles.
REQ-027 SHALL, for N=1, execute COMPUTE for 1 cycle.

Reset
REQ-028 SHALL, while rst is high, immediately force IDLE, clear all accumulators, skew registers and the counter, and drive busy, done, result_valid, result_flat and ovf_flat to 0.
REQ-029 SHALL make assertion of rst mid-COMPUTE abort the job with no done pulse; the first start after rst deasserts begins a fresh job.

Configuration
REQ-030 SHALL be controlled by the macro SYSTOLIC_SAT_EN.
REQ-031 SHALL, when SYSTOLIC_SAT_EN is defined, clamp a shifted value outside the signed DATA_WIDTH range to 0x7FFF/0x8000 (DATA_WIDTH=16) and set the matching ovf_flat bit; otherwise the bit is 0.
REQ-032 SHALL, when SYSTOLIC_SAT_EN is undefined, truncate the shifted value to its low DATA_WIDTH bits and tie ovf_flat to 0.

Structure
REQ-033 SHALL take the fixed-point format constants (S5.10 and S1.6 fractional bits, default FRAC_SHIFT) and the FSM state enum from the shared package systolic_pkg.
REQ-034 SHALL implement one sub-module, systolic_pe_mac, containing the registered data/weight pass-through, the accumulator and the synchronous clear.

Verification
REQ-035 SHALL verify: N=2, A=B=identity (A diagonal 0x0400, B diagonal 0x40) -> result diagonal 0x0400, off-diagonal 0x0000, done 6 edges after start.
REQ-036 SHALL verify: N=2, A[0][0]=0xFC00 (-1.0), B[0][0]=0x20 (0.5), all other elements 0 -> C[0][0]=0xFE00, all others 0.
REQ-037 SHALL verify: N=4, A row 0 all 0x7C00, B column 0 all 0x7F -> C[0][0]=0x7FFF with ovf bit 0 set (macro defined), or 0xD840 with ovf 0 (macro undefined).
REQ-038 SHALL verify: N=4, 100 random jobs against a bit-accurate reference model -> every element matches, and done occurs every 13 cycles with start held high.
REQ-039 SHALL verify: start pulsed again 3 cycles into COMPUTE with different operands -> ignored; result equals the first operand set.
REQ-040 SHALL verify: rst asserted mid-COMPUTE -> all outputs 0 immediately, no done pulse; a new start afterwards yields the correct result.
